// File: rtl/spi_rx_deser_if.sv
// Bundle of SPI receive lines and the word-level valid/ready handshake
// for spi_rx_deser. The master modport is the deserializer's view, the
// slave modport is the view of whoever drives SPI and consumes words.
interface spi_rx_deser_if #(
  parameter int DATA_WIDTH = 16
) ();

  localparam int BCW = $clog2(DATA_WIDTH) + 1;

  logic                  spi_cs_l;
  logic                  spi_clk;
  logic                  spi_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  overrun;
  logic                  frame_err;
  logic [BCW-1:0]        bit_count;

  modport master (
    input  spi_cs_l,
    input  spi_clk,
    input  spi_data,
    input  data_ready,
    output data_out,
    output data_valid,
    output overrun,
    output frame_err,
    output bit_count
  );

  modport slave (
    output spi_cs_l,
    output spi_clk,
    output spi_data,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  overrun,
    input  frame_err,
    input  bit_count
  );

endinterface

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: oversamples spi_cs_l/spi_clk/spi_data in the
// local clk domain, rebuilds MSB-first words and offers each finished word
// on a valid/ready handshake, flagging dropped words and aborted frames.
module spi_rx_deser #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  spi_rx_deser_if.master bus
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic [BCW-1:0]         bit_count_q, bit_count_d;

  logic                   cs_s;
  logic                   sclk_s;
  logic                   data_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;
  logic [DATA_WIDTH-1:0]  word_next;
  logic                   word_done;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s  & ~sclk_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;
  assign cs_rise   = cs_s    & ~cs_prev_q;

  assign word_next = {shreg_q[DATA_WIDTH-2:0], data_s};

  // Equal-length shift chains keep CS, SCLK and DATA aligned in time.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_l};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.spi_data};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
  end

  // Synchroniser and edge-history flops; CS resets low so that a frame can
  // only start after CS has been seen high and then falls again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      data_sync_q <= data_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a CS fall opens a frame, a CS rise closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifting, word completion and handshake; CS rise wins over a
  // coincident SCLK rise, and a finished word may land on the same edge
  // that the consumer takes the previous one.
  always_comb begin
    shreg_d      = shreg_q;
    bit_count_d  = bit_count_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = 1'b0;
    frame_err_d  = 1'b0;
    word_done    = 1'b0;

    case (state_q)
      IDLE: begin
        bit_count_d = '0;
        if (cs_fall) shreg_d = '0;
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_count_q != '0) frame_err_d = 1'b1;
          bit_count_d = '0;
          shreg_d     = '0;
        end else if (sclk_rise) begin
          shreg_d = word_next;
          if (bit_count_q == LAST_BIT) begin
            word_done   = 1'b1;
            bit_count_d = '0;
          end else begin
            bit_count_d = bit_count_q + BCW'(1);
          end
        end
      end
      default: begin
        bit_count_d = '0;
      end
    endcase

    if (word_done) begin
      if (!data_valid_q || bus.data_ready) begin
        data_out_d   = word_next;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && bus.data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q      <= '0;
      bit_count_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_count_q  <= bit_count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.bit_count  = bit_count_q;

endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

SPI receive-side deserializer that sits directly downstream of the team's 16-bit SPI master transmitter. It samples the `spi_cs_l` / `spi_clk` / `spi_data` lines in the local `clk` domain and reassembles MSB-first words. It presents each complete word on a valid/ready interface to the consuming logic. It also flags aborted frames and words dropped because the consumer was not ready.

## Interface
- `DATA_WIDTH`, 16: bits per word; also the number of `spi_clk` rising edges per word.
- `SYNC_STAGES`, 2: flop stages on each SPI input (minimum 2).
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `spi_cs_l`  in  1: chip select, active low.
- `spi_clk`  in  1: serial clock; data sampled on its rising edge.
- `spi_data`  in  1: serial data, MSB first.
- `data_out`  out  DATA_WIDTH: last accepted complete word.
- `data_valid`  out  1: `data_out` holds an unconsumed word.
- `data_ready`  in  1: consumer accepts `data_out` at a clk edge where `data_valid && data_ready`.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.
- `frame_err`  out  1: one-cycle pulse when CS deasserts mid-word.
- `bit_count`  out  $clog2(DATA_WIDTH)+1: bits received in the current word, 0..DATA_WIDTH-1.

## Operation
- **Input synchronisation**
  - `spi_cs_l`, `spi_clk` and `spi_data` each pass through an equal-length SYNC_STAGES chain, so the three lines stay aligned.
  - `sclk_prev` and `cs_prev` register the last stage of the corresponding chains.
- **Edge detection**, from the synchronised lines:
  - `sclk_rise` = sync sclk high && `sclk_prev` low.
  - `cs_fall` = sync cs low && `cs_prev` high.
  - `cs_rise` = sync cs high && `cs_prev` low.
- **IDLE** (sync cs high):
  - `bit_count` is held at 0.
  - `sclk_rise` is ignored.
  - On `cs_fall`, go to SHIFT with `bit_count` = 0.
- **SHIFT** (sync cs low):
  - On each `sclk_rise`, shift the register left and insert sync data at the LSB.
  - Also on `sclk_rise`, `bit_count` increments.
  - When the increment would reach DATA_WIDTH, the word is complete:
    - assembled word = {shreg[DATA_WIDTH-2:0], data}
    - `bit_count` wraps to 0 and the block stays in SHIFT, so back-to-back words are received without a CS toggle.
- **Word completion**, resolved at the clk edge where the word completes:
  - `data_valid` low, or `data_valid && data_ready`: load `data_out` and set `data_valid` = 1.
  - `data_valid && !data_ready`: `data_out` keeps the old word, the new word is discarded, and `overrun` pulses for 1 cycle.
- **Consumption**: `data_valid && data_ready` with no word completing clears `data_valid` at that edge.
- **`cs_rise` in SHIFT**:
  - `bit_count` != 0: pulse `frame_err` for 1 cycle, discard the partial word, set `bit_count` = 0, go to IDLE.
  - `bit_count` == 0: go to IDLE silently.
- **Simultaneous `cs_rise` and `sclk_rise`**: the `sclk_rise` is not shifted. CS has priority.
- **Reset**: asserting `reset` at any time, including mid-word, forces every register to its reset value. Reception resumes only after a subsequent `cs_fall`.

## Timing
- **Reset values**: `data_out` = 0, `data_valid` = 0, `overrun` = 0, `frame_err` = 0, `bit_count` = 0, state = IDLE, shift register = 0.
- **Latency**:
  - Let edge E be the clk edge at which a raw `spi_clk` rise is first captured.
  - That bit is shifted at edge E+SYNC_STAGES.
  - For the last bit of a word, `data_valid` / `data_out` are updated at edge E+SYNC_STAGES.
- **Input timing requirements**:
  - `spi_data` must be stable from 1 clk before to 1 clk after each raw `spi_clk` rise.
  - Every `spi_clk` and `spi_cs_l` level must be held ≥1 clk cycle.
  - The team's master (1 clk high, 1 clk low per bit) meets this when run from the same `clk`.
  - An asynchronous source must hold each level ≥2 clk cycles.
- **Throughput**:
  - One bit per detected `sclk_rise`.
  - A consumer holding `data_ready` high never sees `overrun`.
- **Output behaviour**:
  - `overrun` and `frame_err` are registered and last exactly 1 cycle.
  - `data_out` is stable while `data_valid` is high and not consumed.

## Test plan
- **Single word**: `data_ready` = 1, master-style frame 0xA5C3 (CS low, 16 bits, CS high) -> `data_out` = 0xA5C3, `data_valid` high 1 cycle, `frame_err` = 0, `overrun` = 0.
- **Back-to-back with backpressure**: 0x1234 then 0xFFFF with `data_ready` = 0 -> `data_out` stays 0x1234, `overrun` pulses once when the 16th bit of 0xFFFF is sampled. Then `data_ready` = 1 -> `data_valid` drops next edge.
- **Aborted frame**: CS deasserts after 7 bits -> `frame_err` 1-cycle pulse, `bit_count` returns to 0, no `data_valid`. A following full 0x00FF frame -> `data_out` = 0x00FF.
- **Same-edge load and accept**: `data_valid` high with old word 0x1111, `data_ready` asserted on the exact cycle word 0x2222 completes -> `data_out` = 0x2222, `data_valid` stays 1, `overrun` = 0.
- **Ignored clocks and reset**:
  - `spi_clk` toggled 20 times with CS high -> `bit_count` = 0, no outputs change.
  - `reset` asserted low after bit 9 of a frame -> all outputs 0 immediately.
  - A fresh 0x8001 frame after release -> `data_out` = 0x8001.
- **Latency check**: with SYNC_STAGES = 3, measure the last raw `spi_clk` rise capture to `data_valid` -> exactly 3 clk edges.
